// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, write-back, reservation, scoreboard
// and clear-sweep handshake. The master drives requests; the register file is the slave.
interface regfile_mp_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic                     init_req;
  logic                     ready;

  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*XLEN-1:0]   rd_data;
  logic [NUM_RD-1:0]        rd_busy;

  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [XLEN-1:0]          wr_data;

  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [DEPTH-1:0]         busy_vec;

  modport master (
    output init_req, rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  ready, rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  init_req, rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output ready, rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with RAW scoreboard and hardware clear sweep.
// Optional: define REGFILE_BYPASS_EN to forward same-cycle write data to reads.
module regfile_mp #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic          sys_clk,
  input  logic          rstn,
  regfile_mp_if.slave   rf
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

  state_t                        state_q, state_d;
  logic [ADDR_W-1:0]             cnt_q;
  logic [XLEN-1:0]               mem [DEPTH];
  logic [DEPTH-1:0]              busy_q;
  logic [NUM_RD-1:0][XLEN-1:0]   rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]             rd_busy_q, rd_busy_d;
  logic [ADDR_W-1:0]             rd_addr_p [NUM_RD];
  logic                          op_en, wr_fire, rsv_fire, clr_fire;

  // Normal operation is only accepted in IDLE when no clear is being requested.
  always_comb begin
    op_en    = (state_q == IDLE) && !rf.init_req;
    clr_fire = (state_q == IDLE) &&  rf.init_req;
    wr_fire  = op_en && rf.wr_en  && (rf.wr_addr  != '0);
    rsv_fire = op_en && rf.rsv_en && (rf.rsv_addr != '0);
  end

  // FSM state register
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) state_q <= INIT;
    else       state_q <= state_d;
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    rf.ready = 1'b0;
    case (state_q)
      INIT: if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
      IDLE: begin
        rf.ready = 1'b1;
        if (rf.init_req) state_d = INIT;
      end
      default: state_d = INIT;
    endcase
  end

  // Sweep counter wraps to 0 on the last entry, so it is ready for the next sweep.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn)                 cnt_q <= '0;
    else if (state_q == INIT)  cnt_q <= cnt_q + 1'b1;
    else                       cnt_q <= '0;
  end

  // NOTE: the array has no reset; the INIT sweep zeroes it, keeping it RAM-inferable.
  always_ff @(posedge sys_clk) begin
    if (state_q == INIT) mem[cnt_q]      <= '0;
    else if (wr_fire)    mem[rf.wr_addr] <= rf.wr_data;
  end

  // Scoreboard: a reserve is applied after the write so it wins on the same address.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= '0;
    end else if (clr_fire) begin
      busy_q <= '0;
    end else begin
      if (wr_fire)  busy_q[rf.wr_addr]  <= 1'b0;
      if (rsv_fire) busy_q[rf.rsv_addr] <= 1'b1;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) rd_addr_p[p] = rf.rd_addr[p*ADDR_W +: ADDR_W];
  end

  // Read-port next values; ports hold when disabled and read 0 through a sweep.
  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    for (int p = 0; p < NUM_RD; p++) begin
      if (!op_en) begin
        rd_data_d[p] = '0;
        rd_busy_d[p] = 1'b0;
      end else if (rf.rd_en[p]) begin
        if (rd_addr_p[p] == '0) begin
          rd_data_d[p] = '0;
          rd_busy_d[p] = 1'b0;
`ifdef REGFILE_BYPASS_EN
        end else if (wr_fire && (rf.wr_addr == rd_addr_p[p])) begin
          rd_data_d[p] = rf.wr_data;
          rd_busy_d[p] = rsv_fire && (rf.rsv_addr == rd_addr_p[p]);
`endif
        end else begin
          rd_data_d[p] = mem[rd_addr_p[p]];
          rd_busy_d[p] = busy_q[rd_addr_p[p]];
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rf.rd_data  = rd_data_q;
  assign rf.rd_busy  = rd_busy_q;
  assign rf.busy_vec = busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// compared against an array-based reference model of the register file.
module tb_regfile_mp;
  localparam int XLEN   = 64;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic sys_clk = 1'b0;
  logic rstn    = 1'b1;
  int   errors  = 0;
  int   checks  = 0;

  regfile_mp_if #(.XLEN(XLEN), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

  regfile_mp #(.XLEN(XLEN), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .rf      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: register contents, scoreboard, sweep progress, read-port values.
  logic [XLEN-1:0] m_mem     [DEPTH];
  logic [DEPTH-1:0] m_busy;
  bit              m_init;
  int              m_cnt;
  logic [XLEN-1:0] m_rd_data [NUM_RD];
  logic [NUM_RD-1:0] m_rd_busy;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic clear_inputs();
    bus.init_req = 1'b0;
    bus.rd_en    = '0;
    bus.rd_addr  = '0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
  endtask

  task automatic set_read(input int p, input int r);
    bus.rd_en[p] = 1'b1;
    bus.rd_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(r);
  endtask

  // Apply the behavioural rules to the current inputs, then advance one clock.
  task automatic tick();
    int a;
    if (m_init) begin
      m_mem[m_cnt] = '0;
      for (int p = 0; p < NUM_RD; p++) m_rd_data[p] = '0;
      m_rd_busy = '0;
      if (m_cnt == DEPTH - 1) m_init = 1'b0;
      m_cnt = (m_cnt + 1) % DEPTH;
    end else if (bus.init_req) begin
      m_init = 1'b1;
      m_cnt  = 0;
      m_busy = '0;
      for (int p = 0; p < NUM_RD; p++) m_rd_data[p] = '0;
      m_rd_busy = '0;
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        if (bus.rd_en[p]) begin
          a = int'(bus.rd_addr[p*ADDR_W +: ADDR_W]);
          if (a == 0) begin
            m_rd_data[p] = '0;
            m_rd_busy[p] = 1'b0;
          end else if (BYPASS && bus.wr_en && int'(bus.wr_addr) == a) begin
            m_rd_data[p] = bus.wr_data;
            m_rd_busy[p] = bus.rsv_en && int'(bus.rsv_addr) == a;
          end else begin
            m_rd_data[p] = m_mem[a];
            m_rd_busy[p] = m_busy[a];
          end
        end
      end
      if (bus.wr_en && bus.wr_addr != 0) begin
        m_mem[bus.wr_addr]  = bus.wr_data;
        m_busy[bus.wr_addr] = 1'b0;
      end
      if (bus.rsv_en && bus.rsv_addr != 0) m_busy[bus.rsv_addr] = 1'b1;
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic assert_reset();
    rstn = 1'b0;
    #2;
    m_init = 1'b1;
    m_cnt  = 0;
    m_busy = '0;
    for (int p = 0; p < NUM_RD; p++) m_rd_data[p] = '0;
    m_rd_busy = '0;
  endtask

  task automatic release_reset();
    @(posedge sys_clk);
    #1;
    rstn = 1'b1;
  endtask

  // Bounded wait for ready; returns the number of edges taken (or -1 on timeout).
  task automatic wait_ready(output int n);
    n = -1;
    for (int i = 1; i <= DEPTH + 8; i++) begin
      tick();
      if (bus.ready === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    for (int r = 0; r < DEPTH; r++) m_mem[r] = '0;
    #1;
    assert_reset();
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.ready); end
    checks++; if (bus.busy_vec !== '0) begin errors++; $display("FAIL reset_busy_vec: got %h expected 0", bus.busy_vec); end
    checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", bus.rd_data); end
    checks++; if (bus.rd_busy !== '0) begin errors++; $display("FAIL reset_rd_busy: got %b expected 0", bus.rd_busy); end
    @(posedge sys_clk);
    release_reset();
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd5;
    bus.wr_data = 64'hDEAD;
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      checks++;
      if (bus.ready !== (i == DEPTH)) begin
        errors++; $display("FAIL sweep_ready_edge%0d: got %b expected %b", i, bus.ready, i == DEPTH);
      end
    end
    clear_inputs();
    for (int r = 0; r < DEPTH; r += NUM_RD) begin
      for (int p = 0; p < NUM_RD; p++) set_read(p, r + p);
      tick();
      for (int p = 0; p < NUM_RD; p++) begin
        checks++;
        if (bus.rd_data[p*XLEN +: XLEN] !== '0) begin
          errors++; $display("FAIL post_reset_r%0d: got %h expected 0", r + p, bus.rd_data[p*XLEN +: XLEN]);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_write_read();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 64'h1234;
    tick();
    clear_inputs();
    set_read(0, 7); set_read(1, 7);
    tick();
    clear_inputs();
    for (int p = 0; p < NUM_RD; p++) begin
      checks++;
      if (bus.rd_data[p*XLEN +: XLEN] !== 64'h1234) begin
        errors++; $display("FAIL read_r7_port%0d: got %h expected 1234", p, bus.rd_data[p*XLEN +: XLEN]);
      end
    end
  endtask

  task automatic test_reg_zero();
    bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = 64'hFFFF;
    tick();
    clear_inputs();
    set_read(0, 0); set_read(1, 0);
    bus.rsv_en = 1'b1; bus.rsv_addr = '0;
    tick();
    clear_inputs();
    checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL read_r0: got %h expected 0", bus.rd_data); end
    checks++; if (bus.rd_busy !== '0) begin errors++; $display("FAIL read_r0_busy: got %b expected 0", bus.rd_busy); end
    checks++; if (bus.busy_vec[0] !== 1'b0) begin errors++; $display("FAIL rsv_r0: got %b expected 0", bus.busy_vec[0]); end
  endtask

  task automatic test_scoreboard();
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
    tick();
    clear_inputs();
    checks++; if (bus.busy_vec[3] !== 1'b1) begin errors++; $display("FAIL rsv_r3: got %b expected 1", bus.busy_vec[3]); end
    set_read(0, 3);
    tick();
    clear_inputs();
    checks++; if (bus.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL rd_busy_r3: got %b expected 1", bus.rd_busy[0]); end
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 64'h55;
    tick();
    clear_inputs();
    checks++; if (bus.busy_vec[3] !== 1'b0) begin errors++; $display("FAIL wr_clears_r3: got %b expected 0", bus.busy_vec[3]); end
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 64'h66;
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
    tick();
    clear_inputs();
    checks++; if (bus.busy_vec[3] !== 1'b1) begin errors++; $display("FAIL rsv_wins_r3: got %b expected 1", bus.busy_vec[3]); end
    set_read(1, 3);
    tick();
    clear_inputs();
    checks++; if (bus.rd_data[XLEN +: XLEN] !== 64'h66) begin errors++; $display("FAIL rsv_wr_data_r3: got %h expected 66", bus.rd_data[XLEN +: XLEN]); end
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] exp_d;
    logic            exp_b;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 64'h1;
    tick();
    bus.wr_data = 64'hABCD;
    set_read(0, 9);
    tick();
    clear_inputs();
    exp_d = BYPASS ? 64'hABCD : 64'h1;
    checks++; if (bus.rd_data[0 +: XLEN] !== exp_d) begin errors++; $display("FAIL same_cycle_r9: got %h expected %h", bus.rd_data[0 +: XLEN], exp_d); end
    checks++; if (bus.rd_busy[0] !== 1'b0) begin errors++; $display("FAIL same_cycle_r9_busy: got %b expected 0", bus.rd_busy[0]); end
    // Write, reserve and read of one register together.
    bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 64'h77;
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9;
    set_read(1, 9);
    tick();
    clear_inputs();
    exp_d = BYPASS ? 64'h77 : 64'hABCD;
    exp_b = BYPASS;
    checks++; if (bus.rd_data[XLEN +: XLEN] !== exp_d) begin errors++; $display("FAIL same_cycle_rsv_r9: got %h expected %h", bus.rd_data[XLEN +: XLEN], exp_d); end
    checks++; if (bus.rd_busy[1] !== exp_b) begin errors++; $display("FAIL same_cycle_rsv_r9_busy: got %b expected %b", bus.rd_busy[1], exp_b); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bus.init_req = ($urandom_range(0, 199) == 0);
      bus.rd_en    = NUM_RD'($urandom);
      for (int p = 0; p < NUM_RD; p++)
        bus.rd_addr[p*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 7));
      bus.wr_en    = $urandom_range(0, 1) == 1;
      bus.wr_addr  = ADDR_W'($urandom_range(0, 7));
      bus.wr_data  = {$urandom, $urandom};
      bus.rsv_en   = $urandom_range(0, 2) == 0;
      bus.rsv_addr = ADDR_W'($urandom_range(0, 7));
      tick();
      checks++;
      if (bus.ready !== !m_init) begin errors++; $display("FAIL rand%0d_ready: got %b expected %b", c, bus.ready, !m_init); end
      checks++;
      if (bus.busy_vec !== m_busy) begin errors++; $display("FAIL rand%0d_busy_vec: got %h expected %h", c, bus.busy_vec, m_busy); end
      for (int p = 0; p < NUM_RD; p++) begin
        checks++;
        if (bus.rd_data[p*XLEN +: XLEN] !== m_rd_data[p]) begin
          errors++; $display("FAIL rand%0d_rd_data%0d: got %h expected %h", c, p, bus.rd_data[p*XLEN +: XLEN], m_rd_data[p]);
        end
        checks++;
        if (bus.rd_busy[p] !== m_rd_busy[p]) begin
          errors++; $display("FAIL rand%0d_rd_busy%0d: got %b expected %b", c, p, bus.rd_busy[p], m_rd_busy[p]);
        end
      end
    end
    clear_inputs();
    if (m_init) begin
      int n;
      wait_ready(n);
    end
  endtask

  task automatic test_init_req();
    int n;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 64'h1234;
    tick();
    clear_inputs();
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
    tick();
    clear_inputs();
    bus.init_req = 1'b1;
    tick();
    clear_inputs();
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL init_req_ready: got %b expected 0", bus.ready); end
    checks++; if (bus.busy_vec !== '0) begin errors++; $display("FAIL init_req_busy_vec: got %h expected 0", bus.busy_vec); end
    wait_ready(n);
    checks++; if (n != DEPTH) begin errors++; $display("FAIL init_sweep_len: got %0d expected %0d", n, DEPTH); end
    set_read(0, 7);
    tick();
    clear_inputs();
    checks++; if (bus.rd_data[0 +: XLEN] !== '0) begin errors++; $display("FAIL r7_after_sweep: got %h expected 0", bus.rd_data[0 +: XLEN]); end
    // Reset in the middle of a sweep restarts it from entry 0.
    bus.init_req = 1'b1;
    tick();
    clear_inputs();
    for (int i = 0; i < 10; i++) tick();
    assert_reset();
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL midsweep_reset_ready: got %b expected 0", bus.ready); end
    release_reset();
    wait_ready(n);
    checks++; if (n != DEPTH) begin errors++; $display("FAIL midsweep_restart_len: got %0d expected %0d", n, DEPTH); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_reg_zero();
    test_scoreboard();
    test_bypass();
    test_random();
    test_init_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
